tt09_array_multiplier: RTL and testbench



---
 rtl/tt09_array_multiplier.sv | 106 ++++++++++
 tb/tb_tt09_array_multiplier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tt09_array_multiplier.sv
// tt09_array_multiplier
//   Registered unsigned 4x4 multiplier built from a structural AND /
//   full-adder array. Operands are packed on the dedicated input bus and the
//   8-bit product is loaded into the output register on each enabled edge.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous reset, ACTIVE HIGH (tile pin name retained)
//   ena      in   1  output register load enable
//   ui_in    in   8  [7:4] operand A, [3:0] operand B (unsigned)
//   uio_in   in   8  unused
//   uo_out   out  8  registered product A*B
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (all bidirectionals are inputs)

// Single full-adder cell; a half adder is this cell with c tied low.
module tt09_array_multiplier_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);
endmodule

module tt09_array_multiplier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] pp [4];
  logic [7:0] product;

  assign op_a = ui_in[7:4];
  assign op_b = ui_in[3:0];

  // pp[i][j] = A[j] & B[i]
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pp[i] = op_a & {4{op_b[i]}};
    end
  end

  // Rows 1..3: add partial-product row i to the running sum shifted right by
  // one (previous row's carry-out enters as the MSB). Row and bit signals
  // live in their own generate scopes so each ripple stage is a distinct
  // net rather than a bit of a self-referencing vector.
  for (genvar i = 1; i < 4; i++) begin : g_row
    logic [3:0] b_in;
    logic [3:0] sum;
    logic       cout;

    if (i == 1) begin : g_first
      assign b_in = {1'b0, pp[0][3:1]};
    end else begin : g_next
      assign b_in = {g_row[i-1].cout, g_row[i-1].sum[3:1]};
    end

    for (genvar k = 0; k < 4; k++) begin : g_bit
      logic ci;
      logic co;
      if (k == 0) begin : g_lsb
        assign ci = 1'b0;
      end else begin : g_chain
        assign ci = g_bit[k-1].co;
      end
      tt09_array_multiplier_fa u_fa (
        .a    (pp[i][k]),
        .b    (b_in[k]),
        .c    (ci),
        .sum  (sum[k]),
        .cout (co)
      );
    end

    assign cout = g_bit[3].co;
  end

  assign product = {g_row[3].cout, g_row[3].sum,
                    g_row[2].sum[0], g_row[1].sum[0], pp[0][0]};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      uo_out <= '0;
    end else if (ena) begin
      uo_out <= product;
    end
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt09_array_multiplier.sv
module tb_tt09_array_multiplier;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests;
  int fails;

  tt09_array_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'hA5;
    #2;
    tests++;
    if (uo_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: got %h expected %h", uo_out, 8'h00);
    end
    tests++;
    if (uio_oe !== 8'h00) begin
      fails++;
      $display("FAIL reset_oe: got %h expected %h", uio_oe, 8'h00);
    end
    tests++;
    if (uio_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_uio_out: got %h expected %h", uio_out, 8'h00);
    end
    // Reset must dominate ena across a clock edge.
    tick();
    tests++;
    if (uo_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_beats_ena: got %h expected %h", uo_out, 8'h00);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_basic();
    ui_in = 8'h35;
    tick();
    tests++;
    if (uo_out !== 8'h0F) begin
      fails++;
      $display("FAIL basic_3x5: got %h expected %h", uo_out, 8'h0F);
    end
    ui_in = 8'hFF;
    tick();
    tests++;
    if (uo_out !== 8'hE1) begin
      fails++;
      $display("FAIL basic_15x15: got %h expected %h", uo_out, 8'hE1);
    end
  endtask

  task automatic test_zero_identity();
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    vin[0] = 8'h0F; vexp[0] = 8'h00;
    vin[1] = 8'h1F; vexp[1] = 8'h0F;
    vin[2] = 8'hF1; vexp[2] = 8'h0F;
    vin[3] = 8'h80; vexp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ui_in = vin[i];
      tick();
      tests++;
      if (uo_out !== vexp[i]) begin
        fails++;
        $display("FAIL zero_identity in=%h: got %h expected %h",
                 vin[i], uo_out, vexp[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    ui_in = 8'h77;
    tick();
    tests++;
    if (uo_out !== 8'h31) begin
      fails++;
      $display("FAIL hold_load: got %h expected %h", uo_out, 8'h31);
    end
    ena   = 1'b0;
    ui_in = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (uo_out !== 8'h31) begin
        fails++;
        $display("FAIL hold_cycle%0d: got %h expected %h", i, uo_out, 8'h31);
      end
    end
    ena = 1'b1;
    tick();
    tests++;
    if (uo_out !== 8'h04) begin
      fails++;
      $display("FAIL hold_resume: got %h expected %h", uo_out, 8'h04);
    end
  endtask

  task automatic test_async_reset();
    ui_in = 8'hFF;
    tick();
    tests++;
    if (uo_out !== 8'hE1) begin
      fails++;
      $display("FAIL async_preload: got %h expected %h", uo_out, 8'hE1);
    end
    #2;
    rst_n = 1'b1;
    #1;
    tests++;
    if (uo_out !== 8'h00) begin
      fails++;
      $display("FAIL async_clear: got %h expected %h", uo_out, 8'h00);
    end
    ui_in = 8'h96;
    #1;
    rst_n = 1'b0;
    tick();
    tests++;
    if (uo_out !== 8'h36) begin
      fails++;
      $display("FAIL async_release: got %h expected %h", uo_out, 8'h36);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] expv;
    logic [3:0] a;
    logic [3:0] b;
    for (int v = 0; v < 256; v++) begin
      ui_in  = v[7:0];
      uio_in = 8'($urandom);
      a      = v[7:4];
      b      = v[3:0];
      expv   = 8'(a) * 8'(b);
      tick();
      tests++;
      if (uo_out !== expv || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        fails++;
        $display("FAIL sweep in=%h: got %h/%h/%h expected %h/00/00",
                 v[7:0], uo_out, uio_out, uio_oe, expv);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_zero_identity();
    test_enable_hold();
    test_async_reset();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
